// File: rtl/register_dump_unit_pkg.sv
// Shared types and constants for the register dump unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package register_dump_unit_pkg;

    localparam int NB_DATA_DEF        = 32;
    localparam int NB_REG_ADDRESS_DEF = 5;
    localparam int N_REGS_DEF         = 32;
    localparam int NB_BYTE_DEF        = 8;

    localparam logic [7:0] HEADER_BYTE    = 8'hA5;
    localparam int         BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_ADDR,
        ST_LATCH,
        ST_SEND,
        ST_NEXT,
        ST_DONE,
        ST_HEADER
    } dump_state_t;

    function automatic int bytes_per_word(input int nb_data, input int nb_byte);
        return nb_data / nb_byte;
    endfunction

endpackage

// File: rtl/register_dump_unit_if.sv
// Register-file debug read port plus byte stream toward the UART transmitter.
// Latency: n/a (wiring only).
// Backpressure: tx_valid/tx_ready handshake on the byte stream.
interface register_dump_unit_if
    import register_dump_unit_pkg::*;
#(
    parameter int NB_DATA        = NB_DATA_DEF,
    parameter int NB_REG_ADDRESS = NB_REG_ADDRESS_DEF,
    parameter int NB_BYTE        = NB_BYTE_DEF
);
    logic [NB_REG_ADDRESS-1:0] direc_lectura_debug;
    logic [NB_DATA-1:0]        dato_debug;
    logic [NB_BYTE-1:0]        tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (
        output direc_lectura_debug,
        input  dato_debug,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  direc_lectura_debug,
        output dato_debug,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/register_dump_unit_word_serializer.sv
// Loads a word and emits it MSB byte first on a valid/ready stream.
// Latency: first byte valid the cycle after load_i; one byte per cycle with ready high.
// Backpressure: data and valid are held until tx_ready_i; valid never drops without a transfer.
module register_dump_unit_word_serializer
    import register_dump_unit_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_BYTE = NB_BYTE_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               load_i,
    input  logic               load_single_i,
    input  logic [NB_DATA-1:0] load_word_i,
    input  logic               tx_ready_i,
    output logic [NB_BYTE-1:0] tx_data_o,
    output logic               tx_valid_o,
    output logic               last_byte_sent_o
);
    localparam int BPW   = bytes_per_word(NB_DATA, NB_BYTE);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

    logic [NB_DATA-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               xfer;

    assign xfer             = valid_q && tx_ready_i;
    assign last_byte_sent_o = xfer && (cnt_q == LAST_CNT);
    assign tx_data_o        = shift_q[NB_DATA-1 -: NB_BYTE];
    assign tx_valid_o       = valid_q;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            // A single-byte load starts on the last count so it ends after one transfer
            shift_d = load_word_i;
            cnt_d   = load_single_i ? LAST_CNT : '0;
            valid_d = 1'b1;
        end else if (xfer) begin
            if (cnt_q == LAST_CNT) begin
                valid_d = 1'b0;
            end else begin
                shift_d = shift_q << NB_BYTE;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/register_dump_unit.sv
// Dumps registers 0..N_REGS-1 MSB byte first on a byte stream; REG_DUMP_HEADER_EN prepends 8'hA5.
// Latency: first byte valid 2 cycles after start (1 with header); 7 cycles per register at full rate.
// Backpressure: stalls in place while tx_ready is low; start is ignored while busy.
module register_dump_unit
    import register_dump_unit_pkg::*;
#(
    parameter int NB_DATA        = NB_DATA_DEF,
    parameter int NB_REG_ADDRESS = NB_REG_ADDRESS_DEF,
    parameter int N_REGS         = N_REGS_DEF,
    parameter int NB_BYTE        = NB_BYTE_DEF
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    register_dump_unit_if.master dbg_if,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam logic [NB_REG_ADDRESS-1:0] ADDR_LAST = NB_REG_ADDRESS'(N_REGS - 1);

    dump_state_t               state_q, state_d;
    logic [NB_REG_ADDRESS-1:0] addr_q, addr_d;
    logic                      ser_load;
    logic                      ser_single;
    logic [NB_DATA-1:0]        ser_word;
    logic                      ser_last;

    register_dump_unit_word_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .load_i           (ser_load),
        .load_single_i    (ser_single),
        .load_word_i      (ser_word),
        .tx_ready_i       (dbg_if.tx_ready),
        .tx_data_o        (dbg_if.tx_data),
        .tx_valid_o       (dbg_if.tx_valid),
        .last_byte_sent_o (ser_last)
    );

    assign dbg_if.direc_lectura_debug = addr_q;
    assign o_busy                     = (state_q != ST_IDLE);
    assign o_done                     = (state_q == ST_DONE);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ser_load   = 1'b0;
        ser_single = 1'b0;
        ser_word   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    addr_d  = '0;
`ifdef REG_DUMP_HEADER_EN
                    state_d = ST_HEADER;
`else
                    state_d = ST_SET_ADDR;
`endif
                end
            end
            ST_HEADER: begin
                // Load on the entry cycle only; afterwards wait for the single byte to go out
                if (!dbg_if.tx_valid) begin
                    ser_load   = 1'b1;
                    ser_single = 1'b1;
                    ser_word   = NB_DATA'(HEADER_BYTE) << (NB_DATA - NB_BYTE);
                end else if (ser_last) begin
                    state_d = ST_SET_ADDR;
                end
            end
            ST_SET_ADDR: state_d = ST_LATCH;
            ST_LATCH: begin
                ser_load = 1'b1;
                ser_word = dbg_if.dato_debug;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (ser_last) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + NB_REG_ADDRESS'(1);
                    state_d = ST_SET_ADDR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

endmodule
